cmpx_mult4_seq: RTL and testbench

CMPX_MULT4_SEQ -- requirements
Module: cmpx_mult4_seq

---
 rtl/cmpx_mult4_seq_if.sv | 21 ++
 rtl/cmpx_mult4_seq.sv | 144 ++++++++++++++
 tb/tb_cmpx_mult4_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cmpx_mult4_seq_if.sv
// Operand/result bundle for cmpx_mult4_seq.
// The master drives start/a/b, and the slave returns the result and done.
interface cmpx_mult4_seq_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] out;
  logic [7:0]  outReal;
  logic [7:0]  outImag;
  logic        done;

  modport master (
    output start, a, b,
    input  out, outReal, outImag, done
  );

  modport slave (
    input  start, a, b,
    output out, outReal, outImag, done
  );
endinterface

// File: rtl/cmpx_mult4_seq.sv
// Sequential 4-bit complex multiplier: one shift-add multiplier, one add/sub.
// Optional macro CMPX_MULT_ACCUMULATE_EN: results accumulate across starts.
module cmpx_mult4_seq (
  input  logic clk,
  input  logic rst,
  cmpx_mult4_seq_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MUL0, S_ACC0,
    S_MUL1, S_ACC1,
    S_MUL2, S_ACC2,
    S_MUL3, S_ACC3,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0] r_x;
  logic [3:0] r_y;
  logic [3:0] r_z;
  logic [3:0] r_w;
  logic [1:0] r_cnt;
  logic [7:0] r_prod;
  logic [7:0] r_re;
  logic [7:0] r_im;
  logic       r_done;

  logic       w_accept;
  logic       w_mul;
  logic       w_acc;
  logic [1:0] w_phase;
  logic       w_sub;
  logic       w_to_re;
  logic [3:0] w_mcand;
  logic [3:0] w_mplier;
  logic [7:0] w_pp;
  logic [7:0] w_acc_in;
  logic [7:0] w_addend;
  logic [7:0] w_sum;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_MUL0;
      S_DONE:  if (bus.start) w_next = S_MUL0;
      S_MUL0:  if (r_cnt == 2'd3) w_next = S_ACC0;
      S_ACC0:  w_next = S_MUL1;
      S_MUL1:  if (r_cnt == 2'd3) w_next = S_ACC1;
      S_ACC1:  w_next = S_MUL2;
      S_MUL2:  if (r_cnt == 2'd3) w_next = S_ACC2;
      S_ACC2:  w_next = S_MUL3;
      S_MUL3:  if (r_cnt == 2'd3) w_next = S_ACC3;
      S_ACC3:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_mul    = 1'b0;
    w_acc    = 1'b0;
    w_phase  = 2'd0;
    unique case (r_state)
      S_IDLE: w_accept = bus.start;
      S_DONE: w_accept = bus.start;
      S_MUL0: begin w_mul = 1'b1; w_phase = 2'd0; end
      S_ACC0: begin w_acc = 1'b1; w_phase = 2'd0; end
      S_MUL1: begin w_mul = 1'b1; w_phase = 2'd1; end
      S_ACC1: begin w_acc = 1'b1; w_phase = 2'd1; end
      S_MUL2: begin w_mul = 1'b1; w_phase = 2'd2; end
      S_ACC2: begin w_acc = 1'b1; w_phase = 2'd2; end
      S_MUL3: begin w_mul = 1'b1; w_phase = 2'd3; end
      S_ACC3: begin w_acc = 1'b1; w_phase = 2'd3; end
      default: ;
    endcase
  end

  // phase 0: +x*z re, 1: -y*w re, 2: +x*w im, 3: +y*z im
  assign w_sub    = (w_phase == 2'd1);
  assign w_to_re  = ~w_phase[1];
  assign w_mcand  = w_phase[0] ? r_y : r_x;
  assign w_mplier = (w_phase[0] ^ w_phase[1]) ? r_w : r_z;
  assign w_pp     = w_mplier[r_cnt]
                  ? ({4'd0, w_mcand} << r_cnt)
                  : 8'd0;
  assign w_acc_in = w_to_re ? r_re : r_im;
  assign w_addend = w_sub ? ~r_prod : r_prod;
  assign w_sum    = w_acc_in + w_addend + {7'd0, w_sub};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_w    <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
      r_re   <= '0;
      r_im   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (w_next == S_DONE);
      if (w_accept) begin
        r_x    <= bus.a[7:4];
        r_y    <= bus.a[3:0];
        r_z    <= bus.b[7:4];
        r_w    <= bus.b[3:0];
        r_cnt  <= '0;
        r_prod <= '0;
`ifdef CMPX_MULT_ACCUMULATE_EN
        r_re   <= r_re;
        r_im   <= r_im;
`else
        r_re   <= '0;
        r_im   <= '0;
`endif
      end
      if (w_mul) begin
        r_prod <= r_prod + w_pp;
        r_cnt  <= r_cnt + 2'd1;
      end
      if (w_acc) begin
        r_prod <= '0;
        r_cnt  <= '0;
        if (w_to_re) r_re <= w_sum;
        else         r_im <= w_sum;
      end
    end
  end

  assign bus.out     = {r_re, r_im};
  assign bus.outReal = r_re;
  assign bus.outImag = r_im;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_cmpx_mult4_seq.sv
// Scoreboard bench for cmpx_mult4_seq.
// An arithmetic model pushes the expected results, and the done event pops them.
module tb_cmpx_mult4_seq;

  logic clk = 1'b0;
  logic rst;

  cmpx_mult4_seq_if bus ();

  cmpx_mult4_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sb_q[$];
  logic [7:0]  m_re;
  logic [7:0]  m_im;
  logic [15:0] m_prev;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_start(logic [7:0] a, logic [7:0] b);
    int x, y, z, w;
    x = int'(a[7:4]);
    y = int'(a[3:0]);
    z = int'(b[7:4]);
    w = int'(b[3:0]);
`ifndef CMPX_MULT_ACCUMULATE_EN
    m_re = 8'd0;
    m_im = 8'd0;
`endif
    m_prev = {m_re, m_im};
    m_re = 8'(int'(m_re) + x * z - y * w);
    m_im = 8'(int'(m_im) + x * w + y * z);
    sb_q.push_back({m_re, m_im});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out", bus.out, 16'h0000);
    check("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_re = 8'd0;
    m_im = 8'd0;
    sb_q.delete();
  endtask

  task automatic start_op(logic [7:0] a, logic [7:0] b, bit hold);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    model_start(a, b);
    @(posedge clk);
    #1;
    check("done_drop", bus.done, 1'b0);
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_done(string tag, bit hold);
    int n;
    logic [15:0] exp;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 4) check({tag, "_mulhold"}, bus.out, m_prev);
      if (hold && n == 7) begin
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
      end
    end
    if (hold) bus.start = 1'b0;
    check({tag, "_lat"}, n, 20);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_out"}, bus.out, exp);
      check({tag, "_re"}, bus.outReal, exp[15:8]);
      check({tag, "_im"}, bus.outImag, exp[7:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    m_re = 8'd0;
    m_im = 8'd0;
    m_prev = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("init_out", bus.out, 16'h0000);
    check("init_done", bus.done, 1'b0);
    do_reset();

    start_op(8'h23, 8'h21, 1'b0);
    wait_done("v23", 1'b0);
    check("v23_const", bus.out, 16'h0108);
    @(posedge clk);
    #1;
    check("done_hold", bus.done, 1'b1);
    check("out_hold", bus.out, {m_re, m_im});
    start_op(8'h23, 8'h21, 1'b0);
    wait_done("v23b", 1'b0);
`ifdef CMPX_MULT_ACCUMULATE_EN
    check("b2b_const", bus.out, 16'h0210);
`else
    check("b2b_const", bus.out, 16'h0108);
`endif

    do_reset();
    start_op(8'h22, 8'h12, 1'b0);
    wait_done("v22", 1'b0);
    do_reset();
    start_op(8'h10, 8'h13, 1'b0);
    wait_done("v10", 1'b0);
    do_reset();
    start_op(8'h0F, 8'h0F, 1'b0);
    wait_done("v0f", 1'b0);
    do_reset();
    start_op(8'hF0, 8'hF0, 1'b0);
    wait_done("vf0", 1'b0);

    start_op(8'hF0, 8'hF0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out", bus.out, 16'h0000);
    check("abort_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_re = 8'd0;
    m_im = 8'd0;
    sb_q.delete();
    repeat (25) @(posedge clk);
    #1;
    check("abort_idle", bus.done, 1'b0);
    check("abort_idle_out", bus.out, 16'h0000);
    start_op(8'h35, 8'h7A, 1'b0);
    wait_done("post_abort", 1'b0);

    do_reset();
    start_op(8'h57, 8'h9C, 1'b1);
    wait_done("hold", 1'b1);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      start_op(8'($urandom), 8'($urandom), 1'b0);
      wait_done("rnd", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
